// File: rtl/address_window.sv
// rtl/address_window.sv - registered address window hit detector with offset
//
// Purpose: on each rising Clock edge, samples Address/Base/Head and reports
// whether Address fell inside the half-open window [Base, Head), together with
// the offset of Address from Base. Outputs are registered (1-cycle latency) and
// cleared asynchronously by Reset.
//
// Configuration macro: ADDRESS_WINDOW_WRAP_EN
//   defined   - a window with Base > Head wraps across the top of the space
//   undefined - a window with Base > Head is empty (never hits)
//
// Ports:
//   Clock   in  1      rising-edge clock
//   Reset   in  1      asynchronous active-high reset, clears Valid/Offset
//   Address in  WIDTH  address under test
//   Base    in  WIDTH  window start, inclusive
//   Head    in  WIDTH  window end, exclusive
//   Valid   out 1      registered address was inside the window
//   Offset  out WIDTH  registered Address - Base when Valid, else 0
module address_window #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Address,
  input  logic [WIDTH-1:0] Base,
  input  logic [WIDTH-1:0] Head,
  output logic             Valid,
  output logic [WIDTH-1:0] Offset
);

  logic             valid_d;
  logic             valid_q;
  logic [WIDTH-1:0] offset_d;
  logic [WIDTH-1:0] offset_q;

  logic at_or_above_base;
  logic below_head;
  logic normal_window;
  logic wrapped_window;

  always_comb begin
    at_or_above_base = (Address >= Base);
    below_head       = (Address <  Head);
    normal_window    = (Base < Head);
    wrapped_window   = (Base > Head);

    valid_d = 1'b0;
    if (normal_window) begin
      valid_d = at_or_above_base && below_head;
    end
`ifdef ADDRESS_WINDOW_WRAP_EN
    else if (wrapped_window) begin
      // Window spans the top of the address space: hit on either side.
      valid_d = at_or_above_base || below_head;
    end
`endif

    // Subtraction wraps modulo 2^WIDTH, which is exactly the offset for both
    // normal and wrapped windows.
    offset_d = valid_d ? (Address - Base) : '0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      valid_q  <= 1'b0;
      offset_q <= '0;
    end else begin
      valid_q  <= valid_d;
      offset_q <= offset_d;
    end
  end

  assign Valid  = valid_q;
  assign Offset = offset_q;

`ifndef ADDRESS_WINDOW_WRAP_EN
  // Only consumed when wrapping is enabled.
  logic unused_wrapped;
  assign unused_wrapped = wrapped_window;
`endif

endmodule

// File: tb/tb_address_window.sv
// tb/tb_address_window.sv - directed self-checking bench for address_window
module tb_address_window;

  localparam int WIDTH = 16;

  logic             Clock;
  logic             Reset;
  logic [WIDTH-1:0] Address;
  logic [WIDTH-1:0] Base;
  logic [WIDTH-1:0] Head;
  logic             Valid;
  logic [WIDTH-1:0] Offset;

  int tests_run;
  int tests_failed;

  address_window #(.WIDTH(WIDTH)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Address (Address),
    .Base    (Base),
    .Head    (Head),
    .Valid   (Valid),
    .Offset  (Offset)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive a vector on the falling edge, then sample just after the next rise.
  task automatic drive_and_clock(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] h);
    @(negedge Clock);
    Address = a;
    Base    = b;
    Head    = h;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset   = 1'b1;
    Address = 16'h0305;
    Base    = 16'h0300;
    Head    = 16'h0400;
    #1;
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_t0 got %b exp 0", Valid); end
    repeat (2) @(posedge Clock);
    #1;
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_clocked got %b exp 0", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL reset_offset_clocked got %h exp 0000", Offset); end
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic test_normal_window;
    drive_and_clock(16'h0300, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b1) begin tests_failed++; $display("FAIL normal_base_valid got %b exp 1", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL normal_base_offset got %h exp 0000", Offset); end
    drive_and_clock(16'h03FF, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b1) begin tests_failed++; $display("FAIL normal_last_valid got %b exp 1", Valid); end
    tests_run++;
    if (Offset !== 16'h00FF) begin tests_failed++; $display("FAIL normal_last_offset got %h exp 00ff", Offset); end
    drive_and_clock(16'h0400, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL normal_head_valid got %b exp 0", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL normal_head_offset got %h exp 0000", Offset); end
    drive_and_clock(16'h0342, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b1) begin tests_failed++; $display("FAIL normal_mid_valid got %b exp 1", Valid); end
    tests_run++;
    if (Offset !== 16'h0042) begin tests_failed++; $display("FAIL normal_mid_offset got %h exp 0042", Offset); end
  endtask

  task automatic test_outside;
    drive_and_clock(16'h02FF, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL below_base_valid got %b exp 0", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL below_base_offset got %h exp 0000", Offset); end
    drive_and_clock(16'hFFFF, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL top_addr_valid got %b exp 0", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL top_addr_offset got %h exp 0000", Offset); end
  endtask

  task automatic test_empty_window;
    drive_and_clock(16'h1000, 16'h1000, 16'h1000);
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL empty_valid got %b exp 0", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL empty_offset got %h exp 0000", Offset); end
  endtask

  task automatic test_inverted_window;
    logic             exp_v_in;
    logic [WIDTH-1:0] exp_off_low;
`ifdef ADDRESS_WINDOW_WRAP_EN
    exp_v_in    = 1'b1;
    exp_off_low = 16'h0090;
`else
    exp_v_in    = 1'b0;
    exp_off_low = 16'h0000;
`endif
    drive_and_clock(16'h0010, 16'hFF80, 16'h0080);
    tests_run++;
    if (Valid !== exp_v_in) begin tests_failed++; $display("FAIL inv_low_valid got %b exp %b", Valid, exp_v_in); end
    tests_run++;
    if (Offset !== exp_off_low) begin tests_failed++; $display("FAIL inv_low_offset got %h exp %h", Offset, exp_off_low); end
    drive_and_clock(16'hFF80, 16'hFF80, 16'h0080);
    tests_run++;
    if (Valid !== exp_v_in) begin tests_failed++; $display("FAIL inv_base_valid got %b exp %b", Valid, exp_v_in); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL inv_base_offset got %h exp 0000", Offset); end
    drive_and_clock(16'h0080, 16'hFF80, 16'h0080);
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL inv_head_valid got %b exp 0", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL inv_head_offset got %h exp 0000", Offset); end
  endtask

  task automatic test_reset_pulse;
    drive_and_clock(16'h0305, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b1 || Offset !== 16'h0005) begin
      tests_failed++; $display("FAIL pulse_setup got %b/%h exp 1/0005", Valid, Offset);
    end
    #2;
    Reset = 1'b1;
    #1;
    tests_run++;
    if (Valid !== 1'b0) begin tests_failed++; $display("FAIL pulse_async_valid got %b exp 0", Valid); end
    tests_run++;
    if (Offset !== 16'h0000) begin tests_failed++; $display("FAIL pulse_async_offset got %h exp 0000", Offset); end
    #2;
    Reset = 1'b0;
    #1;
    tests_run++;
    if (Valid !== 1'b0 || Offset !== 16'h0000) begin
      tests_failed++; $display("FAIL pulse_released_before_edge got %b/%h exp 0/0000", Valid, Offset);
    end
    @(posedge Clock);
    #1;
    tests_run++;
    if (Valid !== 1'b1) begin tests_failed++; $display("FAIL pulse_reload_valid got %b exp 1", Valid); end
    tests_run++;
    if (Offset !== 16'h0005) begin tests_failed++; $display("FAIL pulse_reload_offset got %h exp 0005", Offset); end
  endtask

  task automatic test_mid_cycle_hold;
    drive_and_clock(16'h0300, 16'h0300, 16'h0400);
    tests_run++;
    if (Valid !== 1'b1 || Offset !== 16'h0000) begin
      tests_failed++; $display("FAIL hold_setup got %b/%h exp 1/0000", Valid, Offset);
    end
    #2;
    Address = 16'h0500;
    #1;
    tests_run++;
    if (Valid !== 1'b1 || Offset !== 16'h0000) begin
      tests_failed++; $display("FAIL hold_mid_cycle got %b/%h exp 1/0000", Valid, Offset);
    end
    @(posedge Clock);
    #1;
    tests_run++;
    if (Valid !== 1'b0 || Offset !== 16'h0000) begin
      tests_failed++; $display("FAIL hold_after_edge got %b/%h exp 0/0000", Valid, Offset);
    end
  endtask

  task automatic test_back_to_back;
    // Consecutive hits with different offsets, one per cycle.
    for (int i = 0; i < 4; i++) begin
      drive_and_clock(16'h2000 + 16'(i * 16'h0041), 16'h2000, 16'h2100);
      tests_run++;
      if (Valid !== 1'b1 || Offset !== 16'(i * 16'h0041)) begin
        tests_failed++;
        $display("FAIL b2b_%0d got %b/%h exp 1/%h", i, Valid, Offset, 16'(i * 16'h0041));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_normal_window();
    test_outside();
    test_empty_window();
    test_inverted_window();
    test_reset_pulse();
    test_mid_cycle_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
